// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage to data-memory bus bridge; registered req/ack transaction with pipeline stall.
// Optional DMEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT_CYCLES and pulses bus_err_o.
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  input  logic        flush_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic drop, drop_n, req_n, err_n, issue, tmo_hit;
  logic [31:0] rdata_q, rdata_n;
  if (2 ** TMO_W <= TIMEOUT_CYCLES) begin : g_bad_tmo_w
    $error("TMO_W too narrow for TIMEOUT_CYCLES");
  end
`ifdef DMEM_TIMEOUT_EN
  logic [TMO_W-1:0] tmo;
  assign tmo_hit = state == BUSY && !bus_ack_i && tmo == TMO_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) tmo <= '0;
    else tmo <= state == BUSY ? tmo + 1'b1 : '0;
`else
  assign tmo_hit = 1'b0;
`endif
  assign stallreq_o = state == IDLE ? mem_ce_i & ~flush_i : state == BUSY;
  assign mem_data_o = state == DONE ? rdata_q : 32'h0;
  always_comb begin
    state_n = state;
    drop_n = drop;
    rdata_n = rdata_q;
    req_n = bus_req_o;
    err_n = 1'b0;
    issue = 1'b0;
    case (state)
      IDLE: if (mem_ce_i && !flush_i) begin
        issue = 1'b1;
        req_n = 1'b1;
        state_n = BUSY;
      end
      BUSY: begin
        drop_n = drop | flush_i;
        if (bus_ack_i || tmo_hit) begin
          req_n = 1'b0;
          err_n = tmo_hit;
          rdata_n = bus_ack_i && !bus_we_o ? bus_rdata_i : 32'h0;
          state_n = drop | flush_i ? IDLE : DONE;
          drop_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      drop <= 1'b0;
      rdata_q <= '0;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_addr_o <= '0;
      bus_sel_o <= '0;
      bus_wdata_o <= '0;
      bus_err_o <= 1'b0;
    end else begin
      state <= state_n;
      drop <= drop_n;
      rdata_q <= rdata_n;
      bus_req_o <= req_n;
      bus_err_o <= err_n;
      if (issue) begin
        bus_we_o <= mem_we_i;
        bus_addr_o <= mem_addr_i;
        bus_sel_o <= mem_sel_i;
        bus_wdata_o <= mem_data_i;
      end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed vectors with hand-computed expectations for dmem_bridge.
module tb_dmem_bridge;
  logic clk = 0, rst = 1;
  logic mem_ce_i = 0, mem_we_i = 0, flush_i = 0, bus_ack_i = 0;
  logic [31:0] mem_addr_i = 0, mem_data_i = 0, bus_rdata_i = 0;
  logic [3:0] mem_sel_i = 0;
  logic [31:0] mem_data_o, bus_addr_o, bus_wdata_o;
  logic stallreq_o, bus_req_o, bus_we_o, bus_err_o;
  logic [3:0] bus_sel_o;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  dmem_bridge #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
    .flush_i(flush_i), .mem_data_o(mem_data_o), .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #3;
  endtask
  initial begin
    cyc; cyc;
    rst = 0;
    settle;
    check("rst_stall", 32'(stallreq_o), 0);
    check("rst_req", 32'(bus_req_o), 0);
    check("rst_data", mem_data_o, 0);
    check("rst_err", 32'(bus_err_o), 0);
    check("rst_addr", bus_addr_o, 0);
    mem_ce_i = 1; flush_i = 1; settle;
    check("idle_flush_stall", 32'(stallreq_o), 0);
    cyc; flush_i = 0; mem_ce_i = 0; settle;
    check("idle_flush_noreq", 32'(bus_req_o), 0);
    // load word, ack on second BUSY cycle
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h10; mem_sel_i = 4'hF; settle;
    check("lw_issue_stall", 32'(stallreq_o), 1);
    cyc; settle;
    check("lw_b1_req", 32'(bus_req_o), 1);
    check("lw_b1_addr", bus_addr_o, 32'h10);
    check("lw_b1_sel", 32'(bus_sel_o), 32'hF);
    check("lw_b1_we", 32'(bus_we_o), 0);
    check("lw_b1_stall", 32'(stallreq_o), 1);
    check("lw_b1_data", mem_data_o, 0);
    cyc; bus_ack_i = 1; bus_rdata_i = 32'hDEADBEEF; settle;
    check("lw_b2_stall", 32'(stallreq_o), 1);
    cyc; bus_ack_i = 0; mem_ce_i = 0; settle;
    check("lw_done_data", mem_data_o, 32'hDEADBEEF);
    check("lw_done_stall", 32'(stallreq_o), 0);
    check("lw_done_req", 32'(bus_req_o), 0);
    cyc; settle;
    check("lw_idle_data", mem_data_o, 0);
    check("lw_idle_stall", 32'(stallreq_o), 0);
    // store byte, ack on first BUSY cycle
    mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'h3; mem_sel_i = 4'b0001; mem_data_i = 32'h5A5A5A5A;
    cyc; bus_ack_i = 1; bus_rdata_i = 32'hFFFFFFFF; settle;
    check("sb_we", 32'(bus_we_o), 1);
    check("sb_sel", 32'(bus_sel_o), 1);
    check("sb_wdata", bus_wdata_o, 32'h5A5A5A5A);
    check("sb_addr", bus_addr_o, 32'h3);
    cyc; bus_ack_i = 0; mem_ce_i = 0; mem_we_i = 0; settle;
    check("sb_done_data", mem_data_o, 0);
    check("sb_done_stall", 32'(stallreq_o), 0);
    cyc;
    // flush during BUSY: access completes, no DONE, fresh request follows
    mem_ce_i = 1; mem_addr_i = 32'h40; mem_sel_i = 4'hF;
    cyc; flush_i = 1; settle;
    check("fl_b1_stall", 32'(stallreq_o), 1);
    cyc; flush_i = 0; settle;
    check("fl_b2_req", 32'(bus_req_o), 1);
    cyc; bus_ack_i = 1; bus_rdata_i = 32'h12345678; mem_addr_i = 32'h44; settle;
    check("fl_b3_req", 32'(bus_req_o), 1);
    cyc; bus_ack_i = 0; settle;
    check("fl_idle_data", mem_data_o, 0);
    check("fl_idle_req", 32'(bus_req_o), 0);
    check("fl_idle_stall", 32'(stallreq_o), 1);
    cyc; settle;
    check("fl_new_req", 32'(bus_req_o), 1);
    check("fl_new_addr", bus_addr_o, 32'h44);
    bus_ack_i = 1; bus_rdata_i = 32'hCAFE0001;
    cyc; bus_ack_i = 0; mem_ce_i = 0; settle;
    check("fl_new_done", mem_data_o, 32'hCAFE0001);
    cyc;
    // back-to-back loads with ce held
    mem_ce_i = 1; mem_addr_i = 32'h20;
    cyc; bus_ack_i = 1; bus_rdata_i = 32'h11111111;
    cyc; bus_ack_i = 0; mem_addr_i = 32'h24; settle;
    check("bb_done1_data", mem_data_o, 32'h11111111);
    check("bb_done1_stall", 32'(stallreq_o), 0);
    check("bb_done1_req", 32'(bus_req_o), 0);
    cyc; settle;
    check("bb_idle_stall", 32'(stallreq_o), 1);
    check("bb_idle_req", 32'(bus_req_o), 0);
    check("bb_idle_data", mem_data_o, 0);
    cyc; settle;
    check("bb_b2_req", 32'(bus_req_o), 1);
    check("bb_b2_addr", bus_addr_o, 32'h24);
    bus_ack_i = 1; bus_rdata_i = 32'h22222222;
    cyc; bus_ack_i = 0; mem_ce_i = 0; settle;
    check("bb_done2_data", mem_data_o, 32'h22222222);
    cyc;
    // reset mid-BUSY
    mem_ce_i = 1; mem_addr_i = 32'h80;
    cyc; settle;
    check("rb_b1_req", 32'(bus_req_o), 1);
    rst = 1;
    cyc; rst = 0; settle;
    check("rb_req", 32'(bus_req_o), 0);
    check("rb_stall", 32'(stallreq_o), 1);
    check("rb_data", mem_data_o, 0);
    check("rb_addr", bus_addr_o, 0);
    flush_i = 1; settle;
    check("rb_stall_fl", 32'(stallreq_o), 0);
    flush_i = 0; mem_ce_i = 0; bus_ack_i = 1; bus_rdata_i = 32'h99999999;
    cyc; bus_ack_i = 0; settle;
    check("idle_ack_req", 32'(bus_req_o), 0);
    check("idle_ack_data", mem_data_o, 0);
    check("idle_ack_stall", 32'(stallreq_o), 0);
    // unacknowledged load
    mem_ce_i = 1; mem_addr_i = 32'h90;
    cyc;
`ifdef DMEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      settle;
      check("to_busy_err", 32'(bus_err_o), 0);
      check("to_busy_req", 32'(bus_req_o), 1);
      cyc;
    end
    mem_ce_i = 0; settle;
    check("to_err", 32'(bus_err_o), 1);
    check("to_done_data", mem_data_o, 0);
    check("to_done_req", 32'(bus_req_o), 0);
    check("to_done_stall", 32'(stallreq_o), 0);
    bus_ack_i = 1; bus_rdata_i = 32'h77777777;
    cyc; bus_ack_i = 0; settle;
    check("to_late_err", 32'(bus_err_o), 0);
    check("to_late_data", mem_data_o, 0);
    check("to_late_req", 32'(bus_req_o), 0);
`else
    for (int i = 0; i < 6; i++) begin
      settle;
      check("wait_err", 32'(bus_err_o), 0);
      check("wait_req", 32'(bus_req_o), 1);
      check("wait_stall", 32'(stallreq_o), 1);
      cyc;
    end
    bus_ack_i = 1; bus_rdata_i = 32'h77777777;
    cyc; bus_ack_i = 0; mem_ce_i = 0; settle;
    check("wait_done_data", mem_data_o, 32'h77777777);
    check("wait_done_err", 32'(bus_err_o), 0);
`endif
    cyc;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
